// File: rtl/bpm_adjust.sv
// Tempo-setting front end: synchronises, debounces and auto-repeats the up/down buttons into a clamped BPM value.
// Optional feature macro BPM_ADJUST_WRAP_EN: steps past a bound wrap to the opposite bound instead of saturating.
`timescale 1ns/1ps

module bpm_adjust #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter int unsigned MIN_BPM         = 30,
    parameter int unsigned MAX_BPM         = 250,
    parameter int unsigned RESET_BPM       = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [8:0] bpm,
    output logic       bpm_changed
);

`ifdef BPM_ADJUST_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int          DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int          TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
    localparam logic [8:0]    MIN_V       = 9'(MIN_BPM);
    localparam logic [8:0]    MAX_V       = 9'(MAX_BPM);
    localparam logic [8:0]    RESET_V     = 9'(RESET_BPM);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    // Index 0 = up button, index 1 = down button.
    logic [1:0]    sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    bpm_q, bpm_d;
    logic          bpm_changed_q, bpm_changed_d;

    logic          step, step_up, up_only, down_only, held;
    logic [9:0]    bpm_step;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    deb_d[b]     = sync2_q[b];
                    deb_cnt_d[b] = '0;
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end else begin
                deb_cnt_d[b] = '0;
            end
        end
    end

    assign up_only   = deb_q[0] & ~deb_q[1];
    assign down_only = deb_q[1] & ~deb_q[0];
    assign held      = dir_q ? up_only : down_only;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        step    = 1'b0;
        step_up = dir_q;
        unique case (state_q)
            IDLE: begin
                if (up_only || down_only) begin
                    step    = 1'b1;
                    step_up = up_only;
                    dir_d   = up_only;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (timer_q == HOLD_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (timer_q == REPEAT_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Widened to 10 bits so the out-of-range result is visible before clamping or wrapping.
    assign bpm_step = step_up ? {1'b0, bpm_q} + 10'd1 : {1'b0, bpm_q} - 10'd1;

    always_comb begin
        bpm_d = bpm_q;
        if (step) begin
            if (step_up && (bpm_step > {1'b0, MAX_V})) begin
                bpm_d = WRAP_EN ? MIN_V : MAX_V;
            end else if (!step_up && (bpm_step < {1'b0, MIN_V})) begin
                bpm_d = WRAP_EN ? MAX_V : MIN_V;
            end else begin
                bpm_d = bpm_step[8:0];
            end
        end
        bpm_changed_d = (bpm_d != bpm_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_cnt_q[0]  <= '0;
            deb_cnt_q[1]  <= '0;
            state_q       <= IDLE;
            dir_q         <= 1'b0;
            timer_q       <= '0;
            bpm_q         <= RESET_V;
            bpm_changed_q <= 1'b0;
        end else begin
            sync1_q       <= {btn_down, btn_up};
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            state_q       <= state_d;
            dir_q         <= dir_d;
            timer_q       <= timer_d;
            bpm_q         <= bpm_d;
            bpm_changed_q <= bpm_changed_d;
        end
    end

    assign bpm         = bpm_q;
    assign bpm_changed = bpm_changed_q;

endmodule

// File: tb/tb_bpm_adjust.sv
// Scoreboard bench for bpm_adjust: expected (edge, bpm) steps are queued when a press is driven
// and popped by a monitor on every bpm_changed pulse.
`timescale 1ns/1ps

module tb_bpm_adjust;

    localparam int MIN_B = 30;
    localparam int MAX_B = 250;
    localparam int RST_B = 120;

    typedef struct {
        int edge_no;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic [8:0] bpm;
    logic       bpm_changed;

    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    int   model_bpm;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    bpm_adjust #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (5),
        .MIN_BPM        (MIN_B),
        .MAX_BPM        (MAX_B),
        .RESET_BPM      (RST_B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .bpm        (bpm),
        .bpm_changed(bpm_changed)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int step_model(input int v, input bit up);
        if (up) begin
            if (v >= MAX_B) begin
`ifdef BPM_ADJUST_WRAP_EN
                return MIN_B;
`else
                return MAX_B;
`endif
            end
            return v + 1;
        end
        if (v <= MIN_B) begin
`ifdef BPM_ADJUST_WRAP_EN
            return MAX_B;
`else
            return MIN_B;
`endif
        end
        return v - 1;
    endfunction

    // Applies one step to the model and queues a pulse only if the value actually changes.
    task automatic push_step(input int e, input bit up);
        int nv;
        exp_t x;
        nv = step_model(model_bpm, up);
        if (nv != model_bpm) begin
            x.edge_no = e;
            x.val     = nv;
            sb_q.push_back(x);
        end
        model_bpm = nv;
    endtask

    // Holds one button for n clk edges. Edge a is the first edge that samples it high;
    // steps land at a+6, a+26, then every 5 edges while the debounced level is still high (up to a+n+5).
    task automatic press(input bit up, input int n);
        int a;
        int lim;
        a   = cycle + 1;
        lim = a + n + 5;
        if (a + 6 <= lim)  push_step(a + 6, up);
        if (a + 26 <= lim) push_step(a + 26, up);
        for (int e = a + 31; e <= lim; e += 5) push_step(e, up);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        repeat (n) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic mid_cycle_reset(input string tag);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        btn_down = 1'b0;
        #1;
        check({tag, "_bpm"}, bpm, RST_B);
        check({tag, "_pulse"}, bpm_changed, 0);
        model_bpm = RST_B;
    endtask

    always @(negedge clk) begin
        if (!rst && bpm_changed) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse_pending", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_edge", cycle, mon_e.edge_no);
                check("pulse_bpm", bpm, mon_e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int r;
        rst       = 1'b1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        model_bpm = RST_B;

        // Reset state, and it holds after release.
        repeat (3) @(negedge clk);
        check("reset_bpm", bpm, RST_B);
        check("reset_pulse", bpm_changed, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_bpm", bpm, RST_B);
        check("post_reset_pending", sb_q.size(), 0);

        // Single short press: one step at edge 7.
        press(1'b1, 10);
        check("single_bpm", bpm, 121);
        check("single_pending", sb_q.size(), 0);

        // Bounce: 2-cycle runs never survive the debounce window.
        for (int i = 0; i < 12; i++) begin
            btn_up = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_bpm", bpm, 121);
        check("bounce_pending", sb_q.size(), 0);

        // Auto-repeat down: steps at 7, 27, 32 .. 62.
        press(1'b0, 60);
        check("repeat_bpm", bpm, 112);
        check("repeat_pending", sb_q.size(), 0);

        // Saturation (or wrap) at the upper bound.
        press(1'b1, 725);
        check("saturate_bpm", bpm, model_bpm);
        check("saturate_pending", sb_q.size(), 0);

        // Asynchronous mid-cycle reset.
        mid_cycle_reset("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("async_rst_hold_bpm", bpm, RST_B);

        // Conflict: up in REPEAT, then down joins after edge a+33 -> last step at a+36.
        a = cycle + 1;
        push_step(a + 6, 1'b1);
        push_step(a + 26, 1'b1);
        push_step(a + 31, 1'b1);
        push_step(a + 36, 1'b1);
        btn_up = 1'b1;
        while (cycle < a + 33) @(negedge clk);
        btn_down = 1'b1;
        repeat (30) @(negedge clk);
        check("conflict_bpm", bpm, 124);
        check("conflict_pending", sb_q.size(), 0);

        // Reset while held; button still high at release must re-debounce: 121 at R+7.
        mid_cycle_reset("hold_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r   = cycle;
        push_step(r + 7, 1'b1);
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_rearm_bpm", bpm, 121);
        check("rst_rearm_pending", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
